seq_detect_ctrl: RTL and testbench

Front-end controller for the serial pattern detector.
- Accepts parallel words over a valid/ready handshake and serialises them MSB-first, one bit per clock.
- Runs an overlapping match against a programmable PAT_LEN-bit pattern. The reset pattern is 8'b11101000.
- Emits a one-cycle hit pulse and keeps a saturating hit counter for the lab top-level and LED/7-seg display logic.

---
 rtl/seq_detect_pkg.sv | 23 ++
 rtl/seq_detect_match_core.sv | 45 ++++
 rtl/seq_detect_ctrl.sv | 121 ++++++++++++
 tb/tb_seq_detect_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared constants and types for the serial pattern detector front end.
package seq_detect_pkg;

    localparam int WORD_W_DEF  = 8;
    localparam int PAT_LEN_DEF = 8;
    localparam int CNT_W_DEF   = 8;

    localparam logic [PAT_LEN_DEF-1:0] PAT_DEFAULT = 8'b11101000;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT
    } state_t;

    // Width of an index that must reach n-1; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_detect_match_core.sv
// Overlapping matcher: shifts in one bit per valid cycle and pulses hit
// once the last PAT_LEN bits equal the pattern and the window is full.
module seq_match_core #(
    parameter int PAT_LEN = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               bit_valid,
    input  logic               bit_in,
    input  logic [PAT_LEN-1:0] pattern,
    input  logic               clear,
    output logic               hit
);

    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

    logic [PAT_LEN-1:0] history;
    logic [PAT_LEN-1:0] history_next;
    logic [FILL_W-1:0]  fill;
    logic [FILL_W-1:0]  fill_next;

    assign history_next = {history[PAT_LEN-2:0], bit_in};
    assign fill_next    = (fill == FILL_FULL) ? fill : fill + 1'b1;

    // History window, fill level and registered hit; clear restarts the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            history <= '0;
            fill    <= '0;
            hit     <= 1'b0;
        end else if (clear) begin
            history <= '0;
            fill    <= '0;
            hit     <= 1'b0;
        end else if (bit_valid) begin
            history <= history_next;
            fill    <= fill_next;
            hit     <= (history_next == pattern) && (fill_next == FILL_FULL);
        end else begin
            hit     <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Front-end controller: accepts words over valid/ready, serialises them
// MSB-first, feeds the matcher and keeps a saturating hit counter.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no word in flight; ready for a word, pattern writes allowed
// S_SHIFT | serialising; bit_idx is the position of the bit on ser_bit
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int                   WORD_W  = WORD_W_DEF,
    parameter int                   PAT_LEN = PAT_LEN_DEF,
    parameter int                   CNT_W   = CNT_W_DEF,
    parameter logic [PAT_LEN-1:0]   RST_PAT = PAT_LEN'(PAT_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [PAT_LEN-1:0] cfg_pattern,
    input  logic               in_valid,
    input  logic [WORD_W-1:0]  in_data,
    output logic               in_ready,
    output logic               busy,
    output logic               ser_valid,
    output logic               ser_bit,
    output logic               hit,
    output logic [CNT_W-1:0]   hit_cnt,
    input  logic               clr_cnt
);

    localparam int IDX_W = idx_width(WORD_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    state_t             state;
    logic [WORD_W-1:0]  shreg;
    logic [IDX_W-1:0]   bit_idx;
    logic [PAT_LEN-1:0] pattern;
    logic               last_bit;
    logic               cfg_take;

    // The bit on ser_bit is always the top of the shift register, so the
    // serial outputs come straight from flops.
    assign last_bit  = (state == S_SHIFT) && (bit_idx == LAST_IDX);
    assign in_ready  = (state == S_IDLE) || last_bit;
    assign busy      = (state == S_SHIFT);
    assign ser_valid = (state == S_SHIFT);
    assign ser_bit   = shreg[WORD_W-1];
    assign cfg_take  = cfg_we && (state == S_IDLE);

    // Serialiser FSM: load on handshake, shift each cycle, reload on the
    // last bit when another word is waiting so the stream has no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            shreg   <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        shreg   <= in_data;
                        bit_idx <= '0;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (bit_idx == LAST_IDX) begin
                        bit_idx <= '0;
                        if (in_valid) begin
                            shreg <= in_data;
                        end else begin
                            shreg <= '0;
                            state <= S_IDLE;
                        end
                    end else begin
                        shreg   <= {shreg[WORD_W-2:0], 1'b0};
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    shreg   <= '0;
                    bit_idx <= '0;
                end
            endcase
        end
    end

    // Pattern register; writes only land while no word is being shifted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern <= RST_PAT;
        end else if (cfg_take) begin
            pattern <= cfg_pattern;
        end
    end

    seq_match_core #(
        .PAT_LEN (PAT_LEN)
    ) u_match (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_valid (ser_valid),
        .bit_in    (ser_bit),
        .pattern   (pattern),
        .clear     (cfg_take),
        .hit       (hit)
    );

    // Saturating hit counter; a clear coinciding with a hit leaves one count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt <= '0;
        end else if (clr_cnt) begin
            hit_cnt <= hit ? CNT_W'(1) : '0;
        end else if (hit && (hit_cnt != '1)) begin
            hit_cnt <= hit_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench: the driver steps a bit-stream reference model and
// queues the expected per-cycle outputs; the monitor pops and compares.
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [7:0] cfg_pattern;
    logic       in_valid;
    logic [7:0] in_data;
    logic       clr_cnt;

    logic       in_ready,  busy,  ser_valid,  ser_bit,  hit;
    logic [7:0] hit_cnt;
    logic       in_ready2, busy2, ser_valid2, ser_bit2, hit2;
    logic [1:0] hit_cnt2;

    always #5 clk = ~clk;

    seq_detect_ctrl u_dut (
        .clk (clk), .rst_n (rst_n), .cfg_we (cfg_we), .cfg_pattern (cfg_pattern),
        .in_valid (in_valid), .in_data (in_data), .in_ready (in_ready), .busy (busy),
        .ser_valid (ser_valid), .ser_bit (ser_bit), .hit (hit), .hit_cnt (hit_cnt),
        .clr_cnt (clr_cnt)
    );

    seq_detect_ctrl #(.CNT_W (2)) u_dut2 (
        .clk (clk), .rst_n (rst_n), .cfg_we (cfg_we), .cfg_pattern (cfg_pattern),
        .in_valid (in_valid), .in_data (in_data), .in_ready (in_ready2), .busy (busy2),
        .ser_valid (ser_valid2), .ser_bit (ser_bit2), .hit (hit2), .hit_cnt (hit_cnt2),
        .clr_cnt (clr_cnt)
    );

    typedef struct {
        logic v;
        logic b;
        logic rdy;
        logic bsy;
        logic h;
        int   c8;
        int   c2;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    bit   mon_en   = 0;

    // reference model state
    bit       show_q[$];
    bit       win[$];
    int       m_fill;
    logic [7:0] m_pat;
    bit       m_hit;
    int       m_cnt8, m_cnt2;
    bit       m_accept;
    bit       clr_on_hit = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        show_q.delete();
        win.delete();
        m_fill   = 0;
        m_pat    = 8'b11101000;
        m_hit    = 0;
        m_cnt8   = 0;
        m_cnt2   = 0;
        m_accept = 0;
    endtask

    // One clock edge of the behavioural model: the bit currently shown is
    // consumed into a sliding window and compared against the pattern.
    task automatic model_edge(input bit iv, input logic [7:0] d, input bit cw,
                              input logic [7:0] cp, input bit clr);
        int rem;
        bit ready, honor, hit_next, b;
        logic [7:0] v;
        rem      = show_q.size();
        ready    = (rem <= 1);
        m_accept = iv && ready;
        honor    = cw && (rem == 0);
        hit_next = 0;
        if (rem > 0) begin
            b = show_q.pop_front();
            win.push_back(b);
            if (win.size() > 8) void'(win.pop_front());
            m_fill++;
            if (m_fill >= 8) begin
                v = '0;
                foreach (win[i]) v = {v[6:0], win[i]};
                hit_next = (v == m_pat);
            end
        end
        if (clr) begin
            m_cnt8 = m_hit ? 1 : 0;
            m_cnt2 = m_hit ? 1 : 0;
        end else if (m_hit) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3)   m_cnt2++;
        end
        if (honor) begin
            m_pat  = cp;
            win.delete();
            m_fill = 0;
        end
        if (m_accept) for (int i = 7; i >= 0; i--) show_q.push_back(d[i]);
        m_hit = hit_next;
    endtask

    task automatic push_exp();
        exp_t e;
        e.v   = (show_q.size() > 0);
        e.b   = e.v ? show_q[0] : 1'b0;
        e.rdy = (show_q.size() <= 1);
        e.bsy = (show_q.size() > 0);
        e.h   = m_hit;
        e.c8  = m_cnt8;
        e.c2  = m_cnt2;
        exp_q.push_back(e);
    endtask

    // Called #1 after a rising edge: drive inputs for the next edge.
    task automatic step(input bit iv, input logic [7:0] d, input bit cw,
                        input logic [7:0] cp, input bit clr);
        bit clr_e;
        clr_e       = clr || (clr_on_hit && m_hit);
        in_valid    = iv;
        in_data     = d;
        cfg_we      = cw;
        cfg_pattern = cp;
        clr_cnt     = clr_e;
        model_edge(iv, d, cw, cp, clr_e);
        push_exp();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00, 0, 8'h00, 0);
    endtask

    task automatic send_word(input logic [7:0] d);
        int n = 0;
        do begin
            step(1, d, 0, 8'h00, 0);
            n++;
        end while (!m_accept && n < 32);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 0; in_data = '0; cfg_we = 0; cfg_pattern = '0; clr_cnt = 0;
        #1;
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_busy",      busy,      0);
        chk("rst_ser_valid", ser_valid, 0);
        chk("rst_hit",       hit,       0);
        chk("rst_hit_cnt",   hit_cnt,   0);
        chk("rst_hit_cnt2",  hit_cnt2,  0);
        exp_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_exp();
        mon_en = 1;
    endtask

    // Monitor: one expected entry per cycle, compared on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && mon_en) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_underflow", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("ser_valid", ser_valid, e.v);
                    if (e.v) chk("ser_bit", ser_bit, e.b);
                    chk("in_ready",   in_ready,   e.rdy);
                    chk("busy",       busy,       e.bsy);
                    chk("hit",        hit,        e.h);
                    chk("hit_cnt",    hit_cnt,    e.c8);
                    chk("ser_valid2", ser_valid2, e.v);
                    if (e.v) chk("ser_bit2", ser_bit2, e.b);
                    chk("in_ready2",  in_ready2,  e.rdy);
                    chk("busy2",      busy2,      e.bsy);
                    chk("hit2",       hit2,       e.h);
                    chk("hit_cnt2",   hit_cnt2,   e.c2);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd, rp;
        rst_n = 1'b1;
        in_valid = 0; in_data = '0; cfg_we = 0; cfg_pattern = '0; clr_cnt = 0;
        @(posedge clk);
        #1;
        do_reset();

        // default pattern, single word
        send_word(8'hE8);
        idle(4);

        // back-to-back words with in_valid held
        send_word(8'h00);
        send_word(8'hE8);
        send_word(8'hE8);
        idle(4);

        // overlapping matches on 0xAA
        step(0, 8'h00, 1, 8'hAA, 0);
        send_word(8'hAA);
        send_word(8'hAA);
        idle(4);

        // fill gating and a match across a word boundary
        do_reset();
        send_word(8'h07);
        send_word(8'h40);
        idle(4);

        // counter saturation (2-bit instance), then clear coinciding with a hit
        for (int i = 0; i < 5; i++) send_word(8'hE8);
        idle(3);
        clr_on_hit = 1;
        send_word(8'hE8);
        idle(3);
        clr_on_hit = 0;
        step(0, 8'h00, 0, 8'h00, 1);
        idle(2);

        // pattern writes while shifting are dropped
        send_word(8'hE8);
        step(0, 8'h00, 1, 8'h55, 0);
        step(0, 8'h00, 1, 8'h55, 0);
        idle(8);
        send_word(8'hE8);
        idle(3);

        // reset in the middle of a word
        send_word(8'hE8);
        idle(3);
        do_reset();
        idle(10);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rd = ($urandom_range(0, 3) == 0) ? 8'hE8 : 8'($urandom);
            case ($urandom_range(0, 2))
                0:       rp = 8'hE8;
                1:       rp = 8'hAA;
                default: rp = 8'($urandom);
            endcase
            step($urandom_range(0, 3) != 0, rd, $urandom_range(0, 15) == 0, rp,
                 $urandom_range(0, 31) == 0);
        end
        idle(12);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
